// File: rtl/ctr_drbg_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ctr_drbg_update_ctrl
// Purpose  : Sequencer for the CTR_DRBG Update step (no derivation function,
//            SEEDLEN=384, AES-256). Each Update encrypts V+1, V+2 and V+3 on
//            a shared external AES core. It XORs the 384-bit keystream with
//            provided_data and hands the result to the key/V state register
//            block through its start/done handshake.
// Ports    : clk, rst (async, active-high)
//            start/provided_data/cur_key/cur_v : request and operands, taken
//                                                 on an accepted start
//            aes_req/aes_ready/aes_key/aes_pt  : AES request handshake
//            aes_valid/aes_ct                  : AES ciphertext return
//            upd_start/upd_data/upd_done       : state register load
//            busy/done/error                   : status (error is sticky)
// Revision : 1.0 - initial release
// ============================================================================
module ctr_drbg_update_ctrl #(
  parameter int TIMEOUT_CYCLES = 64   // cycles per block in REQ+WAIT; 0 = off
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [383:0] provided_data,
  input  logic [255:0] cur_key,
  input  logic [127:0] cur_v,
  output logic         aes_req,
  input  logic         aes_ready,
  output logic [255:0] aes_key,
  output logic [127:0] aes_pt,
  input  logic         aes_valid,
  input  logic [127:0] aes_ct,
  output logic         upd_start,
  output logic [383:0] upd_data,
  input  logic         upd_done,
  output logic         busy,
  output logic         done,
  output logic         error
);

  // The counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LIMIT =
    TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT     = 3'd2,
    COMMIT   = 3'd3,
    WAIT_UPD = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [383:0]   pd_q, pd_d;
  logic [127:0]   v_q, v_d;
  logic [1:0]     blk_q, blk_d;
  logic [383:0]   temp_q, temp_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           error_q, error_d;
  logic           done_q, done_d;

  logic           timeout_hit;

  // tmo_q counts cycles already spent in REQ+WAIT for the current block, so
  // the TIMEOUT_CYCLES-th cycle is the one where tmo_q equals the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LIMIT);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    pd_d    = pd_q;
    v_d     = v_q;
    blk_d   = blk_q;
    temp_d  = temp_q;
    tmo_d   = tmo_q;
    error_d = error_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = cur_key;
          pd_d    = provided_data;
          v_d     = cur_v + 128'd1;
          blk_d   = 2'd0;
          error_d = 1'b0;
          tmo_d   = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        tmo_d = tmo_q + TW'(1);
        if (timeout_hit) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (aes_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // A ciphertext arriving on the last allowed cycle still counts.
        if (aes_valid) begin
          case (blk_q)
            2'd0:    temp_d[383:256] = aes_ct;
            2'd1:    temp_d[255:128] = aes_ct;
            default: temp_d[127:0]   = aes_ct;
          endcase
          if (blk_q == 2'd2) begin
            state_d = COMMIT;
          end else begin
            blk_d   = blk_q + 2'd1;
            v_d     = v_q + 128'd1;
            tmo_d   = '0;
            state_d = REQ;
          end
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end

      COMMIT: begin
        state_d = WAIT_UPD;
      end

      WAIT_UPD: begin
        if (upd_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      pd_q    <= '0;
      v_q     <= '0;
      blk_q   <= '0;
      temp_q  <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      pd_q    <= pd_d;
      v_q     <= v_d;
      blk_q   <= blk_d;
      temp_q  <= temp_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
      done_q  <= done_d;
    end
  end

  assign aes_req   = (state_q == REQ);
  assign aes_key   = key_q;
  assign aes_pt    = v_q;
  assign upd_start = (state_q == COMMIT);
  assign upd_data  = temp_q ^ pd_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign error     = error_q;

endmodule
`default_nettype wire
